// File: rtl/ifetch_prefetch_unit.sv
// ifetch_prefetch_unit
//
// Instruction fetch stage with a prefetch FIFO. Owns the fetch PC and issues
// at most one instruction-memory request per cycle. Requests are credit-limited
// so that every request in flight is guaranteed a FIFO slot when it returns.
// Presents the FIFO head plus the head PC + PC_INC to the IF/ID register.
// A branch redirect flushes the FIFO and discards every response still in flight.
//
// Optional build macro: IFETCH_DEBUG_EN adds the PC_debug_value and dbg_redirects outputs.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   PC_write          downstream accepts the presented instruction (0 = stall)
//   redirect          branch/jump taken; redirect_PC is the new fetch PC
//   mem_req/mem_addr  memory request valid and word address
//   mem_ready         memory accepts the request this cycle
//   mem_rvalid/rdata  in-order response, latency >= 1
//   inst_valid        Instruction holds a valid FIFO head
//   Instruction       FIFO head (0 when empty)
//   PC_sumado_value   head PC + PC_INC
//   PC_debug_value    (debug) current fetch PC
//   dbg_redirects     (debug) wrapping count of redirect cycles
module ifetch_prefetch_unit #(
  parameter int unsigned width_B    = 32,
  parameter int unsigned Addr_B     = 10,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned PC_INC     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PC_write,
  input  logic               redirect,
  input  logic [width_B-1:0] redirect_PC,
  output logic               mem_req,
  output logic [Addr_B-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [width_B-1:0] mem_rdata,
  output logic               inst_valid,
  output logic [width_B-1:0] Instruction,
  output logic [width_B-1:0] PC_sumado_value
`ifdef IFETCH_DEBUG_EN
  ,
  output logic [width_B-1:0] PC_debug_value,
  output logic [15:0]        dbg_redirects
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [width_B-1:0] ResetPc = width_B'(RESET_PC);
  localparam logic [width_B-1:0] PcInc   = width_B'(PC_INC);
  localparam logic [CntW:0]      Depth   = (CntW + 1)'(FIFO_DEPTH);

  logic [width_B-1:0] fetch_pc_q, fetch_pc_d;
  logic [width_B-1:0] head_pc_q, head_pc_d;
  logic [width_B-1:0] fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [CntW-1:0]    outstanding_q, outstanding_d;
  logic [CntW-1:0]    drop_q, drop_d;

  logic credit_ok;
  logic accept;
  logic resp;
  logic push;
  logic pop;

  // Outputs and handshake decode.
  always_comb begin
    // Each accepted request reserves a FIFO slot until it returns or is dropped.
    credit_ok       = ({1'b0, outstanding_q} + {1'b0, count_q}) < Depth;
    mem_req         = !reset && !redirect && credit_ok;
    mem_addr        = fetch_pc_q[Addr_B-1:0];
    inst_valid      = (count_q != '0);
    Instruction     = inst_valid ? fifo_q[rd_ptr_q] : '0;
    PC_sumado_value = head_pc_q + PcInc;

    accept = mem_req && mem_ready;
    // Responses with nothing outstanding (e.g. stale after reset) are ignored.
    resp   = mem_rvalid && (outstanding_q != '0);
    push   = resp && (drop_q == '0) && !redirect;
    pop    = inst_valid && PC_write && !redirect;
  end

  // Next-state logic.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_pc_d     = head_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (redirect) begin
      fetch_pc_d    = redirect_PC;
      head_pc_d     = redirect_PC;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      // Everything still in flight after this cycle belongs to the old path.
      outstanding_d = outstanding_q - CntW'(resp);
      drop_d        = outstanding_q - CntW'(resp);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + PcInc;
      end
      if (pop) begin
        head_pc_d = head_pc_q + PcInc;
        rd_ptr_d  = rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      count_d       = count_q + CntW'(push) - CntW'(pop);
      outstanding_d = outstanding_q + CntW'(accept) - CntW'(resp);
      if (resp && (drop_q != '0)) begin
        drop_d = drop_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= ResetPc;
      head_pc_q     <= ResetPc;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // FIFO storage needs no reset: reads are masked to 0 while count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mem_rdata;
    end
  end

`ifdef IFETCH_DEBUG_EN
  logic [15:0] dbg_redirects_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_redirects_q <= '0;
    end else if (redirect) begin
      dbg_redirects_q <= dbg_redirects_q + 16'd1;
    end
  end

  assign PC_debug_value = fetch_pc_q;
  assign dbg_redirects  = dbg_redirects_q;
`endif

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Directed bench for ifetch_prefetch_unit. A small in-order memory model with a
// programmable latency serves the default-parameter instance; a second instance
// (RESET_PC = 0x3FF) is driven by hand to exercise address wrap.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_ifetch_prefetch_unit;

  logic        clk;
  logic        reset;
  logic        PC_write;
  logic        redirect;
  logic [31:0] redirect_PC;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] Instruction;
  logic [31:0] PC_sumado_value;

  logic        w_reset;
  logic        w_PC_write;
  logic        w_redirect;
  logic [31:0] w_redirect_PC;
  logic        w_mem_req;
  logic [9:0]  w_mem_addr;
  logic        w_mem_ready;
  logic        w_mem_rvalid;
  logic [31:0] w_mem_rdata;
  logic        w_inst_valid;
  logic [31:0] w_Instruction;
  logic [31:0] w_PC_sumado_value;

`ifdef IFETCH_DEBUG_EN
  logic [31:0] dbg_pc;
  logic [15:0] dbg_cnt;
  logic [31:0] w_dbg_pc;
  logic [15:0] w_dbg_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state.
  int unsigned lat = 1;
  int unsigned mdl_cyc = 0;
  logic        mdl_acc;
  logic [9:0]  mdl_acc_addr;
  logic        mdl_rvalid = 1'b0;
  logic [31:0] mdl_rdata = '0;
  logic        inj_rvalid = 1'b0;
  logic [31:0] inj_rdata = '0;
  logic [9:0]  q_addr[$];
  int unsigned q_due[$];

  assign mem_rvalid = mdl_rvalid | inj_rvalid;
  assign mem_rdata  = inj_rvalid ? inj_rdata : mdl_rdata;

  ifetch_prefetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .PC_write       (PC_write),
    .redirect       (redirect),
    .redirect_PC    (redirect_PC),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .Instruction    (Instruction),
    .PC_sumado_value(PC_sumado_value)
`ifdef IFETCH_DEBUG_EN
    ,
    .PC_debug_value (dbg_pc),
    .dbg_redirects  (dbg_cnt)
`endif
  );

  ifetch_prefetch_unit #(
    .RESET_PC(32'h3FF)
  ) dut_wrap (
    .clk            (clk),
    .reset          (w_reset),
    .PC_write       (w_PC_write),
    .redirect       (w_redirect),
    .redirect_PC    (w_redirect_PC),
    .mem_req        (w_mem_req),
    .mem_addr       (w_mem_addr),
    .mem_ready      (w_mem_ready),
    .mem_rvalid     (w_mem_rvalid),
    .mem_rdata      (w_mem_rdata),
    .inst_valid     (w_inst_valid),
    .Instruction    (w_Instruction),
    .PC_sumado_value(w_PC_sumado_value)
`ifdef IFETCH_DEBUG_EN
    ,
    .PC_debug_value (w_dbg_pc),
    .dbg_redirects  (w_dbg_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  // In-order memory: sample the handshake just before the edge, answer after it.
  always begin
    @(negedge clk);
    #4;
    mdl_acc      = mem_req && mem_ready;
    mdl_acc_addr = mem_addr;
    @(posedge clk);
    #2;
    mdl_cyc++;
    if (reset) begin
      q_addr.delete();
      q_due.delete();
      mdl_rvalid = 1'b0;
    end else begin
      if (mdl_acc) begin
        q_addr.push_back(mdl_acc_addr);
        q_due.push_back(mdl_cyc - 1 + lat);
      end
      if (q_addr.size() > 0 && q_due[0] == mdl_cyc) begin
        mdl_rvalid = 1'b1;
        mdl_rdata  = memval(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        mdl_rvalid = 1'b0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    mem_ready = 1'b0;
    PC_write  = 1'b1;
    redirect  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (q_addr.size() == 0 && !mem_rvalid && !inst_valid) done = 1;
      next_cycle();
      if (done) break;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: pipeline still busy after 40 cycles, required idle");
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req);
    end
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
    end
    n_checks++;
    if (Instruction !== 32'h0) begin
      n_fail++; $display("FAIL reset_instruction: got %h want 0", Instruction);
    end
    n_checks++;
    if (PC_sumado_value !== 32'h1) begin
      n_fail++; $display("FAIL reset_pc_sumado: got %h want 1", PC_sumado_value);
    end
    next_cycle();
  endtask

  task automatic test_wrap();
    w_reset = 1'b0; w_mem_ready = 1'b1; w_PC_write = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_mem_req !== 1'b1 || w_mem_addr !== 10'h3FF) begin
      n_fail++; $display("FAIL wrap_first_req: req %b addr %h want 1 3ff", w_mem_req, w_mem_addr);
    end
    next_cycle();
    w_mem_rvalid = 1'b1; w_mem_rdata = 32'h1111_0000;
    @(negedge clk);
    n_checks++;
    if (w_mem_req !== 1'b1 || w_mem_addr !== 10'h000) begin
      n_fail++; $display("FAIL wrap_second_req: req %b addr %h want 1 000", w_mem_req, w_mem_addr);
    end
    next_cycle();
    w_mem_rdata = 32'h2222_0001; w_mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (w_inst_valid !== 1'b1 || w_Instruction !== 32'h1111_0000 ||
        w_PC_sumado_value !== 32'h400) begin
      n_fail++;
      $display("FAIL wrap_inst0: v %b inst %h pc %h want 1 11110000 400",
               w_inst_valid, w_Instruction, w_PC_sumado_value);
    end
    next_cycle();
    w_mem_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (w_inst_valid !== 1'b1 || w_Instruction !== 32'h2222_0001 ||
        w_PC_sumado_value !== 32'h401) begin
      n_fail++;
      $display("FAIL wrap_inst1: v %b inst %h pc %h want 1 22220001 401",
               w_inst_valid, w_Instruction, w_PC_sumado_value);
    end
    next_cycle();
  endtask

  // Reset release; L=1, no stall: address c in cycle c, instruction c-2 from cycle 2.
  task automatic test_stream();
    reset = 1'b0; PC_write = 1'b1; mem_ready = 1'b1; redirect = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 10'(c)) begin
        n_fail++; $display("FAIL stream_req c%0d: req %b addr %h want 1 %h", c, mem_req, mem_addr, c);
      end
      n_checks++;
      if (c < 2) begin
        if (inst_valid !== 1'b0) begin
          n_fail++; $display("FAIL stream_early_valid c%0d: got %b want 0", c, inst_valid);
        end
      end else if (inst_valid !== 1'b1 || Instruction !== memval(10'(c - 2)) ||
                   PC_sumado_value !== 32'(c - 1)) begin
        n_fail++;
        $display("FAIL stream_inst c%0d: v %b inst %h pc %h want 1 %h %h", c, inst_valid,
                 Instruction, PC_sumado_value, memval(10'(c - 2)), c - 1);
      end
      next_cycle();
    end
  endtask

  // Ten stall cycles starting with head = 8; then release and check order 8..19.
  task automatic test_stall();
    int exp_i = 8;
    PC_write = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (inst_valid !== 1'b1 || Instruction !== memval(10'd8) || PC_sumado_value !== 32'd9) begin
        n_fail++;
        $display("FAIL stall_hold i%0d: v %b inst %h pc %h want 1 %h 9", i, inst_valid,
                 Instruction, PC_sumado_value, memval(10'd8));
      end
      n_checks++;
      if (mem_req !== (i < 2)) begin
        n_fail++; $display("FAIL stall_credit i%0d: mem_req %b want %b", i, mem_req, i < 2);
      end
      next_cycle();
    end
    PC_write = 1'b1;
    for (int i = 0; i < 30 && exp_i < 20; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        n_checks++;
        if (Instruction !== memval(10'(exp_i)) || PC_sumado_value !== 32'(exp_i + 1)) begin
          n_fail++;
          $display("FAIL stall_resume: inst %h pc %h want %h %h", Instruction, PC_sumado_value,
                   memval(10'(exp_i)), exp_i + 1);
        end
        exp_i++;
      end
      next_cycle();
    end
    n_checks++;
    if (exp_i != 20) begin
      n_fail++; $display("FAIL stall_resume_timeout: reached %0d want 20", exp_i);
    end
  endtask

  // L=3: two requests in flight, redirect to 0x40; both returns are discarded.
  task automatic test_redirect_inflight();
    drain();
    lat = 3; mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    redirect = 1'b1; redirect_PC = 32'h40;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL redir_no_req: mem_req %b want 0", mem_req);
    end
    next_cycle();
    redirect = 1'b0;
    for (int k = 3; k < 7; k++) begin
      @(negedge clk);
      n_checks++;
      if (inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL redir_discard k%0d: inst_valid %b inst %h want 0", k, inst_valid,
                           Instruction);
      end
      if (k == 3) begin
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 10'h40) begin
          n_fail++; $display("FAIL redir_new_req: req %b addr %h want 1 040", mem_req, mem_addr);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b1 || Instruction !== memval(10'h40) || PC_sumado_value !== 32'h41) begin
      n_fail++;
      $display("FAIL redir_first_inst: v %b inst %h pc %h want 1 %h 41", inst_valid, Instruction,
               PC_sumado_value, memval(10'h40));
    end
  endtask

  // Redirect in a cycle where a response returns and the head would be popped.
  task automatic test_redirect_collide();
    bit hit = 0;
    bit got = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (inst_valid && mem_rvalid) begin
        redirect = 1'b1; redirect_PC = 32'h80; hit = 1;
      end
      next_cycle();
      if (hit) break;
    end
    redirect = 1'b0;
    n_checks++;
    if (!hit) begin
      n_fail++; $display("FAIL collide_setup: no pop+response cycle within 30 cycles");
    end
    @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b0 || PC_sumado_value !== 32'h81) begin
      n_fail++; $display("FAIL collide_flush: v %b pc %h want 0 81", inst_valid, PC_sumado_value);
    end
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'h80) begin
      n_fail++; $display("FAIL collide_req: req %b addr %h want 1 080", mem_req, mem_addr);
    end
    for (int i = 0; i < 12; i++) begin
      if (inst_valid) begin
        got = 1;
        break;
      end
      next_cycle();
      @(negedge clk);
    end
    n_checks++;
    if (!got || Instruction !== memval(10'h80) || PC_sumado_value !== 32'h81) begin
      n_fail++;
      $display("FAIL collide_first_inst: v %b inst %h pc %h want 1 %h 81", got, Instruction,
               PC_sumado_value, memval(10'h80));
    end
    next_cycle();
  endtask

  // Reset with two requests outstanding; stale returns afterwards must be ignored.
  task automatic test_reset_midstream();
    bit got = 0;
    drain();
    lat = 3; mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    mem_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0 || Instruction !== 32'h0 ||
        PC_sumado_value !== 32'h1) begin
      n_fail++;
      $display("FAIL midreset_outputs: req %b v %b inst %h pc %h want 0 0 0 1", mem_req,
               inst_valid, Instruction, PC_sumado_value);
    end
    next_cycle();
    reset = 1'b0; inj_rvalid = 1'b1; inj_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 10'h0) begin
        n_fail++;
        $display("FAIL midreset_stale i%0d: v %b req %b addr %h want 0 1 000", i, inst_valid,
                 mem_req, mem_addr);
      end
      next_cycle();
      if (i == 1) inj_rvalid = 1'b0;
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        got = 1;
        break;
      end
      next_cycle();
    end
    n_checks++;
    if (!got || Instruction !== memval(10'h0) || PC_sumado_value !== 32'h1) begin
      n_fail++;
      $display("FAIL midreset_restart: v %b inst %h pc %h want 1 %h 1", got, Instruction,
               PC_sumado_value, memval(10'h0));
    end
    next_cycle();
  endtask

  initial begin
    reset = 1'b1; PC_write = 1'b0; redirect = 1'b0; redirect_PC = '0; mem_ready = 1'b0;
    w_reset = 1'b1; w_PC_write = 1'b0; w_redirect = 1'b0; w_redirect_PC = '0;
    w_mem_ready = 1'b0; w_mem_rvalid = 1'b0; w_mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_wrap();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
